// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 serial-port blocks: word sizes, receiver
// state encoding and the Q-Sound SIOC setting the receiver framing assumes.
package jtdsp16_pkg;
  localparam int SIO_WORD_W = 16;
  localparam int SIO_ADDR_W = 8;
  localparam logic [15:0] SIOC_QSOUND = 16'h02E8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sio_state_e;
endpackage

// File: rtl/jtdsp16_sio_sync.sv
// SYNC-deep, cen-gated flop chain per bit for pin-facing inputs.
// SYNC=0 is a plain wire for same-domain sources.
module jtdsp16_sio_sync #(
  parameter int             SYNC    = 0,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         cen,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  generate
    if (SYNC == 0) begin : g_pass
      assign dout = din;
    end else begin : g_chain
      logic [SYNC-1:0][W-1:0] chain;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain <= {SYNC{RST_VAL}};
        end else if (cen) begin
          chain[0] <= din;
          for (int i = 1; i < SYNC; i++) chain[i] <= chain[i-1];
        end
      end
      assign dout = chain[SYNC-1];
    end
  endgenerate
endmodule

// File: rtl/jtdsp16_sio_rx.sv
// DSP16 SIO serial receiver: rebuilds 16-bit MSB-first words plus the 8-bit
// SADD tag. Optional stereo split enabled by JTDSP16_SIO_RX_STEREO_EN.
module jtdsp16_sio_rx
  import jtdsp16_pkg::*;
#(
  parameter int SYNC = 0
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  ock,
  input  logic                  sdi,
  input  logic                  old,
  input  logic                  sadd,
  output logic [SIO_WORD_W-1:0] dout,
  output logic [SIO_ADDR_W-1:0] addr,
  output logic                  dvalid,
  output logic                  ferr,
  output logic                  busy
`ifdef JTDSP16_SIO_RX_STEREO_EN
  ,
  output logic [SIO_WORD_W-1:0] left,
  output logic [SIO_WORD_W-1:0] right,
  output logic                  lr_valid
`endif
);
  logic ock_s, sdi_s, old_s, sadd_s;

  // old resets high so a freshly reset chain looks like an idle line
  jtdsp16_sio_sync #(.SYNC(SYNC), .W(4), .RST_VAL(4'b0010)) u_sync (
    .rst  (rst),
    .clk  (clk),
    .cen  (cen),
    .din  ({ock, sdi, old, sadd}),
    .dout ({ock_s, sdi_s, old_s, sadd_s})
  );

  sio_state_e            state, state_n;
  logic [SIO_WORD_W-1:0] sreg, sreg_n;
  logic [SIO_ADDR_W-1:0] areg, areg_n;
  logic [4:0]            cnt, cnt_n;
  logic                  last_ock, rise, load, abort;

  assign rise = ock_s & ~last_ock;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    areg_n  = areg;
    cnt_n   = cnt;
    load    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE, DONE: begin
        // DONE lasts one cycle but may already catch the next frame's MSB
        state_n = IDLE;
        if (rise && !old_s) begin
          sreg_n  = {{(SIO_WORD_W-1){1'b0}}, sdi_s};
          areg_n  = {{(SIO_ADDR_W-1){1'b0}}, sadd_s};
          cnt_n   = 5'd1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (old_s) begin
          abort   = 1'b1;
          cnt_n   = 5'd0;
          state_n = IDLE;
        end else if (rise) begin
          sreg_n = {sreg[SIO_WORD_W-2:0], sdi_s};
          if (cnt < 5'd8) areg_n = {areg[SIO_ADDR_W-2:0], sadd_s};
          cnt_n = (cnt == 5'd16) ? cnt : cnt + 5'd1;
          if (cnt_n == 5'd16) begin
            load    = 1'b1;
            state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // dout/addr load on the 16th sample so they are already valid while
  // dvalid is high in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      areg     <= '0;
      cnt      <= '0;
      last_ock <= 1'b0;
      dout     <= '0;
      addr     <= '1;
    end else if (cen) begin
      state    <= state_n;
      sreg     <= sreg_n;
      areg     <= areg_n;
      cnt      <= cnt_n;
      last_ock <= ock_s;
      if (load) begin
        dout <= sreg_n;
        addr <= areg_n;
      end
    end
  end

  assign dvalid = cen & (state == DONE);
  assign ferr   = cen & abort;
  assign busy   = (state == SHIFT);

`ifdef JTDSP16_SIO_RX_STEREO_EN
  logic is_right;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left     <= '0;
      right    <= '0;
      is_right <= 1'b0;
    end else if (cen && load) begin
      is_right <= areg_n[0];
      if (areg_n[0]) right <= sreg_n;
      else           left  <= sreg_n;
    end
  end

  assign lr_valid = dvalid & is_right;
`endif
endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Scoreboard bench for jtdsp16_sio_rx: one SYNC=0 and one SYNC=2 instance
// share a randomized transmitter; a monitor per instance pops expectations.
module tb_jtdsp16_sio_rx;
  logic rst, clk, cen, ock, sdi, old, sadd;
  logic [15:0] dout0, dout1;
  logic [7:0]  addr0, addr1;
  logic dvalid0, dvalid1, ferr0, ferr1, busy0, busy1;
  logic [15:0] left0, left1, right0, right1;
  logic lrv0, lrv1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        kind;  // 0 = word, 1 = frame error
    logic [15:0] d;
    logic [7:0]  a;
    logic [15:0] l;
    logic [15:0] r;
    logic        lv;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // reference state: what the receiver should be showing
  logic [15:0] m_dout, m_left, m_right;
  logic [7:0]  m_addr;

  jtdsp16_sio_rx #(.SYNC(0)) u_dut0 (
    .rst(rst), .clk(clk), .cen(cen), .ock(ock), .sdi(sdi), .old(old), .sadd(sadd),
    .dout(dout0), .addr(addr0), .dvalid(dvalid0), .ferr(ferr0), .busy(busy0)
`ifdef JTDSP16_SIO_RX_STEREO_EN
    , .left(left0), .right(right0), .lr_valid(lrv0)
`endif
  );

  jtdsp16_sio_rx #(.SYNC(2)) u_dut1 (
    .rst(rst), .clk(clk), .cen(cen), .ock(ock), .sdi(sdi), .old(old), .sadd(sadd),
    .dout(dout1), .addr(addr1), .dvalid(dvalid1), .ferr(ferr1), .busy(busy1)
`ifdef JTDSP16_SIO_RX_STEREO_EN
    , .left(left1), .right(right1), .lr_valid(lrv1)
`endif
  );

`ifndef JTDSP16_SIO_RX_STEREO_EN
  assign {left0, left1, right0, right1, lrv0, lrv1} = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cen is mostly high with random holes; changes just after posedge
  initial cen = 1'b1;
  always @(posedge clk) begin
    #1 cen = ($urandom_range(3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int id, input logic dv, input logic fe, input logic [15:0] d,
                     input logic [7:0] a, input logic [15:0] l, input logic [15:0] r,
                     input logic lv);
    exp_t e;
    if (dv && fe) chk($sformatf("dut%0d dvalid_and_ferr", id), 1, 0);
    if (!(dv || fe)) begin
      if (lv) chk($sformatf("dut%0d lr_valid_alone", id), 1, 0);
      return;
    end
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      chk($sformatf("dut%0d unexpected_pulse", id), {dv, fe}, 0);
      return;
    end
    e = (id == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d kind", id), fe, e.kind);
    chk($sformatf("dut%0d dout", id), d, e.d);
    chk($sformatf("dut%0d addr", id), a, e.a);
`ifdef JTDSP16_SIO_RX_STEREO_EN
    chk($sformatf("dut%0d left", id), l, e.l);
    chk($sformatf("dut%0d right", id), r, e.r);
    chk($sformatf("dut%0d lr_valid", id), lv, e.lv);
`endif
  endtask

  always @(negedge clk) if (!rst) mon(0, dvalid0, ferr0, dout0, addr0, left0, right0, lrv0);
  always @(negedge clk) if (!rst) mon(1, dvalid1, ferr1, dout1, addr1, left1, right1, lrv1);

  task automatic push(input logic kind, input logic lv);
    exp_t e;
    e.kind = kind; e.d = m_dout; e.a = m_addr;
    e.l = m_left; e.r = m_right; e.lv = lv;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // one transmitter phase: hold pins for one enabled clock
  task automatic phase(input logic o, input logic ol, input logic d, input logic s);
    ock = o; old = ol; sdi = d; sadd = s;
    do @(posedge clk); while (!cen);
    #1;
  endtask

  // nb<16 leaves the frame short: with trail it is aborted via old=1,
  // without trail it is left hanging (for the reset test)
  task automatic send(input logic [15:0] w, input logic [7:0] t, input int nb,
                      input bit lead, input bit trail);
    logic sb;
    if (lead) begin
      phase(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      phase(1'b1, 1'b1, 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < nb; i++) begin
      sb = (i < 8) ? t[7-i] : 1'($urandom);
      phase(1'b0, 1'b0, w[15-i], sb);
      if (i == 15) begin
        m_dout = w;
        m_addr = t;
        if (t[0]) m_right = w; else m_left = w;
        push(1'b0, t[0]);
      end
      phase(1'b1, 1'b0, w[15-i], sb);
    end
    if (nb < 16 && trail) push(1'b1, 1'b0);
    if (trail) phase(1'b0, 1'b1, 1'($urandom), 1'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) phase(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ock = 1'b0; old = 1'b1; sdi = 1'b0; sadd = 1'b0;
    m_dout = '0; m_addr = 8'hFF; m_left = '0; m_right = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout0", dout0, 16'h0);
    chk("reset addr0", addr0, 8'hFF);
    chk("reset dout1", dout1, 16'h0);
    chk("reset addr1", addr1, 8'hFF);
    chk("reset pulses", {dvalid0, ferr0, dvalid1, ferr1}, 4'b0);
    chk("reset busy", {busy0, busy1}, 2'b0);
    rst = 1'b0;
    idle(3);

    send(16'h1234, 8'hA5, 16, 1, 1);
    idle(4);

    send(16'h8001, 8'h5A, 16, 1, 0);
    send(16'h7FFE, 8'hC3, 16, 0, 1);
    idle(4);

    send(16'hDEAD, 8'h77, 9, 1, 1);
    idle(4);
    send(16'hFFFF, 8'hFF, 16, 1, 1);
    idle(4);

    for (int i = 0; i < 40; i++) begin
      phase(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      phase(1'b1, 1'b1, 1'($urandom), 1'($urandom));
      chk("idle busy", {busy0, busy1}, 2'b0);
    end
    idle(4);

    send(16'hBEEF, 8'h3C, 5, 1, 0);
    chk("busy mid-frame", busy0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; ock = 1'b0; old = 1'b1;
    m_dout = '0; m_addr = 8'hFF; m_left = '0; m_right = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset dout", {dout0, dout1}, 32'h0);
    chk("midreset busy", {busy0, busy1}, 2'b0);
    rst = 1'b0;
    idle(3);
    send(16'h0F0F, 8'h96, 16, 1, 1);
    idle(4);

    send(16'h1111, 8'h00, 16, 1, 1);
    send(16'h2222, 8'h01, 16, 1, 1);
    idle(4);

    for (int n = 0; n < 25; n++) begin
      int nb;
      bit tr;
      nb = ($urandom_range(4) == 0) ? $urandom_range(15, 1) : 16;
      tr = (nb < 16) ? 1'b1 : 1'($urandom);
      send(16'($urandom), 8'($urandom), nb, 1'($urandom), tr);
    end
    idle(6);

    repeat (20) @(posedge clk);
    #1;
    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);
    chk("final dout0", dout0, m_dout);
    chk("final dout1", dout1, m_dout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
